ode_ram_arbiter: RTL and testbench

- Parametrised successor to the single-solver RAM hookup. Lets NUM_CH solver/interpolator channels share one RAM that has two read ports and one write port.
- Round-robin arbitration, with an optional bounded burst lock per channel.
- One transaction per granted cycle. Registered read-data return with a valid strobe.
- Sits between the channel engines and the RAM inside the system top.

---
 rtl/ode_pkg.sv | 12 +
 rtl/rr_picker.sv | 28 ++
 rtl/ode_ram_arbiter.sv | 90 +++++++++
 tb/tb_ode_ram_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ode_pkg.sv
// ode_pkg: shared state encoding, defaults and width helper for the RAM arbiter
package ode_pkg;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDRESS_WIDTH = 13;
    typedef enum logic {IDLE_RR = 1'b0, LOCKED = 1'b1} state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin select, first request at or after ptr wins
module rr_picker #(
    parameter int N = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    int j;
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                idx = PW'(j);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ode_ram_arbiter.sv
// ode_ram_arbiter: round-robin sharing of a 2R1W RAM with bounded burst lock
module ode_ram_arbiter
    import ode_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_CH = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_CH-1:0]               CH_REQ,
    input  logic [NUM_CH-1:0]               CH_LOCK,
    input  logic [NUM_CH-1:0]               CH_WE,
    input  logic [NUM_CH*ADDRESS_WIDTH-1:0] CH_ADD_RD1,
    input  logic [NUM_CH*ADDRESS_WIDTH-1:0] CH_ADD_RD2,
    input  logic [NUM_CH*ADDRESS_WIDTH-1:0] CH_ADD_WR,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    CH_DATA_WR,
    output logic [NUM_CH-1:0]               CH_GNT,
    output logic [NUM_CH-1:0]               CH_RVALID,
    output logic [DATA_WIDTH-1:0]           CH_DATA_RD1,
    output logic [DATA_WIDTH-1:0]           CH_DATA_RD2,
    output logic [ADDRESS_WIDTH-1:0]        RAM_ADD_RD1,
    output logic [ADDRESS_WIDTH-1:0]        RAM_ADD_RD2,
    output logic [ADDRESS_WIDTH-1:0]        RAM_ADD_WR,
    output logic [DATA_WIDTH-1:0]           RAM_DATA_WR,
    output logic                            RAM_ENABLE_WR,
    input  logic [DATA_WIDTH-1:0]           RAM_DATA_RD1,
    input  logic [DATA_WIDTH-1:0]           RAM_DATA_RD2
);
    localparam int PW = clog2(NUM_CH);
    state_t          state;
    logic [PW-1:0]   ptr, owner, pick_idx, win, sel;
    logic [NUM_CH-1:0] pick_gnt;
    logic            pick_any, lock_ok, burst_last, gnt_any;
    logic [7:0]      burst_cnt;
    rr_picker #(.N(NUM_CH), .PW(PW)) u_pick (
        .req(CH_REQ),
        .ptr(ptr),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );
    // a falling lock or request ends the burst without granting that cycle
    always_comb begin
        lock_ok = CH_REQ[owner] & CH_LOCK[owner];
        burst_last = (burst_cnt + 8'd1) == 8'(MAX_BURST);
        gnt_any = RST & ((state == LOCKED) ? lock_ok : pick_any);
        win = (state == LOCKED) ? owner : pick_idx;
        sel = gnt_any ? win : '0;
        CH_GNT = !RST ? '0 : (state == LOCKED) ? (lock_ok ? NUM_CH'(1) << owner : '0) : pick_gnt;
        RAM_ADD_RD1 = CH_ADD_RD1[int'(sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        RAM_ADD_RD2 = CH_ADD_RD2[int'(sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        RAM_ADD_WR = CH_ADD_WR[int'(sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        RAM_DATA_WR = CH_DATA_WR[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        RAM_ENABLE_WR = gnt_any & CH_WE[sel];
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE_RR;
            ptr <= '0;
            owner <= '0;
            burst_cnt <= '0;
            CH_RVALID <= '0;
            CH_DATA_RD1 <= '0;
            CH_DATA_RD2 <= '0;
        end else begin
            CH_RVALID <= CH_GNT;
            if (gnt_any) begin
                CH_DATA_RD1 <= RAM_DATA_RD1;
                CH_DATA_RD2 <= RAM_DATA_RD2;
            end
            if (state == IDLE_RR) begin
                if (pick_any) begin
                    ptr <= (pick_idx == PW'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
                    if (CH_LOCK[pick_idx] && MAX_BURST > 1) begin
                        owner <= pick_idx;
                        burst_cnt <= 8'd1;
                        state <= LOCKED;
                    end
                end
            end else if (!lock_ok || burst_last) begin
                state <= IDLE_RR;
                burst_cnt <= '0;
            end else begin
                burst_cnt <= burst_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_ode_ram_arbiter.sv
// tb_ode_ram_arbiter: directed vectors with a queued scoreboard and RAM model
module tb_ode_ram_arbiter;
    localparam int DW = 64;
    localparam int AW = 13;
    localparam int NC = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NC-1:0] ch_req = '0, ch_lock = '0, ch_we = '0;
    logic [NC*AW-1:0] ch_add_rd1, ch_add_rd2, ch_add_wr;
    logic [NC*DW-1:0] ch_data_wr;
    logic [NC-1:0] ch_gnt, ch_rvalid;
    logic [DW-1:0] ch_data_rd1, ch_data_rd2, ram_data_wr, ram_data_rd1, ram_data_rd2;
    logic [AW-1:0] ram_add_rd1, ram_add_rd2, ram_add_wr;
    logic ram_enable_wr;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    typedef struct {logic [NC-1:0] gnt; logic we; logic [NC-1:0] rv;} cyc_t;
    typedef struct {logic [NC-1:0] ch; logic [DW-1:0] d1; logic [DW-1:0] d2;} rd_t;
    cyc_t cq[$];
    rd_t dq[$];
    logic [NC-1:0] prev_gnt = '0;
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    ode_ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CH(NC), .MAX_BURST(3)) dut (
        .CLK(clk), .RST(rst_n), .CH_REQ(ch_req), .CH_LOCK(ch_lock), .CH_WE(ch_we),
        .CH_ADD_RD1(ch_add_rd1), .CH_ADD_RD2(ch_add_rd2), .CH_ADD_WR(ch_add_wr),
        .CH_DATA_WR(ch_data_wr), .CH_GNT(ch_gnt), .CH_RVALID(ch_rvalid),
        .CH_DATA_RD1(ch_data_rd1), .CH_DATA_RD2(ch_data_rd2),
        .RAM_ADD_RD1(ram_add_rd1), .RAM_ADD_RD2(ram_add_rd2), .RAM_ADD_WR(ram_add_wr),
        .RAM_DATA_WR(ram_data_wr), .RAM_ENABLE_WR(ram_enable_wr),
        .RAM_DATA_RD1(ram_data_rd1), .RAM_DATA_RD2(ram_data_rd2)
    );
    assign ram_data_rd1 = mem[ram_add_rd1];
    assign ram_data_rd2 = mem[ram_add_rd2];
    always @(posedge clk) if (ram_enable_wr) mem[ram_add_wr] <= ram_data_wr;
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (cq.size() > 0) begin
            cyc_t c;
            c = cq.pop_front();
            check("gnt", DW'(ch_gnt), DW'(c.gnt));
            check("ram_we", DW'(ram_enable_wr), DW'(c.we));
            check("rvalid", DW'(ch_rvalid), DW'(c.rv));
        end
        if (ch_rvalid != '0) begin
            if (dq.size() == 0) begin
                check("unexpected_rvalid", DW'(ch_rvalid), '0);
            end else begin
                rd_t r;
                r = dq.pop_front();
                check("rvalid_ch", DW'(ch_rvalid), DW'(r.ch));
                check("rd1", ch_data_rd1, r.d1);
                check("rd2", ch_data_rd2, r.d2);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic vec(input logic r, input logic [NC-1:0] q, l, w, g, input logic [DW-1:0] d1, d2);
        cyc_t c;
        rst_n = r;
        ch_req = q;
        ch_lock = l;
        ch_we = w;
        c.gnt = g;
        c.we = |(g & w);
        c.rv = prev_gnt;
        cq.push_back(c);
        if (g != '0) dq.push_back('{g, d1, d2});
        prev_gnt = g;
    endtask
    task automatic step(input logic r, input logic [NC-1:0] q, l, w, g, input logic [DW-1:0] d1, d2);
        tick();
        vec(r, q, l, w, g, d1, d2);
    endtask
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i < NC; i++) begin
            ch_add_rd1[i*AW +: AW] = AW'(16 + i);
            ch_add_rd2[i*AW +: AW] = AW'(20 + i);
            ch_add_wr[i*AW +: AW] = '0;
            ch_data_wr[i*DW +: DW] = '0;
            mem[16 + i] = DW'(32'h100 + i);
            mem[20 + i] = DW'(32'h200 + i);
        end
        mem[5] = 64'hA;
        mem[9] = 64'hB;
        mem[7] = 64'h55;
        repeat (3) step(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        tick();
        ch_add_rd1[2*AW +: AW] = 13'd5;
        ch_add_rd2[2*AW +: AW] = 13'd9;
        vec(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 64'hA, 64'hB);
        tick();
        ch_add_rd1[2*AW +: AW] = 13'd18;
        ch_add_rd2[2*AW +: AW] = 13'd22;
        vec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        step(1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 64'h103, 64'h203);
        repeat (2) begin
            step(1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 64'h100, 64'h200);
            step(1, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 64'h101, 64'h201);
            step(1, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 64'h102, 64'h202);
            step(1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 64'h103, 64'h203);
        end
        step(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 64'h100, 64'h200);
        repeat (3) step(1, 4'b1111, 4'b0010, 4'b0000, 4'b0010, 64'h101, 64'h201);
        step(1, 4'b1111, 4'b0010, 4'b0000, 4'b0100, 64'h102, 64'h202);
        step(1, 4'b1111, 4'b0010, 4'b0000, 4'b1000, 64'h103, 64'h203);
        step(1, 4'b1111, 4'b0010, 4'b0000, 4'b0001, 64'h100, 64'h200);
        step(1, 4'b1111, 4'b0010, 4'b0000, 4'b0010, 64'h101, 64'h201);
        step(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        step(1, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 64'h102, 64'h202);
        tick();
        ch_add_wr[0 +: AW] = 13'd7;
        ch_data_wr[0 +: DW] = 64'h1234;
        vec(1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 64'h100, 64'h200);
        tick();
        ch_add_rd1[3*AW +: AW] = 13'd7;
        vec(1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 64'h1234, 64'h203);
        tick();
        ch_add_rd1[3*AW +: AW] = 13'd19;
        ch_add_rd1[0 +: AW] = 13'd7;
        ch_data_wr[0 +: DW] = 64'h9999;
        vec(1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 64'h1234, 64'h200);
        tick();
        ch_add_rd1[0 +: AW] = 13'd16;
        ch_add_rd1[3*AW +: AW] = 13'd7;
        vec(1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 64'h9999, 64'h203);
        tick();
        ch_add_rd1[3*AW +: AW] = 13'd19;
        vec(1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 64'h101, 64'h201);
        step(0, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 0, 0);
        step(1, 4'b1111, 4'b0010, 4'b0000, 4'b0001, 64'h100, 64'h200);
        repeat (3) step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        for (int i = 0; i < 10 && (cq.size() > 0 || dq.size() > 0); i++) tick();
        if (cq.size() > 0 || dq.size() > 0)
            check("drain", DW'(cq.size() + dq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
